// File: rtl/wb_trace_stage.sv
// wb_trace_stage: write-back stage with a commit-trace FIFO drain port.
// Define WB_RETIRE_CNT_EN to build the 64-bit retired-instruction counter.
module wb_trace_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         ws_allowin,
  input  logic                         ms_to_ws_valid,
  input  logic [1+ADDR_W+2*DATA_W-1:0] ms_to_ws_bus,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [1+ADDR_W+DATA_W-1:0]   ws_to_ds_bus,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [DATA_W-1:0]            trace_pc,
  output logic [DATA_W/8-1:0]          trace_wen,
  output logic [ADDR_W-1:0]            trace_wnum,
  output logic [DATA_W-1:0]            trace_wdata,
  output logic [63:0]                  retire_cnt
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = $clog2(TRACE_DEPTH + 1);

  typedef struct packed {
    logic              gr_we;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pc;
  } ms_ws_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } trace_rec_t;

  ms_ws_t           ws_q;
  logic             ws_valid;
  logic             ws_ready_go;
  logic             commit_we;
  logic             retire;
  logic             fifo_full;
  logic             push;
  logic             pop;
  trace_rec_t       mem [TRACE_DEPTH];
  trace_rec_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Handshake, commit and forwarding decode for the instruction in the stage.
  always_comb begin
    commit_we   = ws_valid && ws_q.gr_we && (ws_q.dest != '0);
    fifo_full   = (count == CNT_W'(TRACE_DEPTH));
    trace_valid = (count != '0);
    pop         = trace_valid && trace_ready;
    ws_ready_go = !commit_we || !fifo_full || pop;
    ws_allowin  = !ws_valid || ws_ready_go;
    retire      = ws_valid && ws_ready_go;
    push        = retire && commit_we;
    rf_we       = commit_we && ws_ready_go;
    rf_waddr    = ws_valid ? ws_q.dest : '0;
    rf_wdata    = ws_valid ? ws_q.result : '0;
    ws_to_ds_bus = {commit_we,
                    commit_we ? ws_q.dest : '0,
                    ws_valid ? ws_q.result : '0};
  end

  // First-word-fall-through head view; fields are masked while empty.
  always_comb begin
    head        = mem[rd_ptr];
    trace_pc    = trace_valid ? head.pc : '0;
    trace_wnum  = trace_valid ? head.wnum : '0;
    trace_wdata = trace_valid ? head.wdata : '0;
    trace_wen   = {(DATA_W/8){trace_valid}};
  end

  // Stage valid bit advances whenever the stage can accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  // Payload is data-only and needs no reset.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      ws_q <= ms_to_ws_bus;
    end
  end

  // Trace record storage, written at the tail on a committing retire.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: ws_q.pc, wnum: ws_q.dest, wdata: ws_q.result};
    end
  end

  // FIFO pointers wrap naturally; occupancy holds on simultaneous push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q;

  // Counts every retiring instruction, writing or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (retire) begin
      retire_q <= retire_q + 64'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_trace_stage.sv
// tb_wb_trace_stage: scoreboard bench for wb_trace_stage.
// Expected writes/records are queued at acceptance, checked by a monitor.
module tb_wb_trace_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ws_allowin;
  logic              ms_valid;
  logic [1+AW+2*DW-1:0] ms_bus;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [1+AW+DW-1:0] ds_bus;
  logic              trace_valid;
  logic              trace_ready;
  logic [DW-1:0]     trace_pc;
  logic [DW/8-1:0]   trace_wen;
  logic [AW-1:0]     trace_wnum;
  logic [DW-1:0]     trace_wdata;
  logic [63:0]       retire_cnt;

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] r;
    logic [DW-1:0] p;
  } rec_t;

  rec_t   rfq[$];
  rec_t   trq[$];
  int     tests = 0;
  int     fails = 0;
  longint ret_exp = 0;
  bit     done;

  wb_trace_stage #(.DATA_W(DW), .ADDR_W(AW), .TRACE_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ws_allowin    (ws_allowin),
    .ms_to_ws_valid(ms_valid),
    .ms_to_ws_bus  (ms_bus),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .ws_to_ds_bus  (ds_bus),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_pc      (trace_pc),
    .trace_wen     (trace_wen),
    .trace_wnum    (trace_wnum),
    .trace_wdata   (trace_wdata),
    .retire_cnt    (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_ret();
`ifdef WB_RETIRE_CNT_EN
    return 64'(ret_exp);
`else
    return 64'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns one step after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] d,
                       input logic [DW-1:0] r, input logic [DW-1:0] p);
    bit ok = 0;
    ms_valid = 1'b1;
    ms_bus = {we, d, r, p};
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ws_allowin) begin
        ok = 1;
        ret_exp++;
        if (we && d != '0) begin
          rfq.push_back('{d: d, r: r, p: p});
          trq.push_back('{d: d, r: r, p: p});
        end
      end
      step();
    end
    if (!ok) chk("issue_timeout", 64'(ws_allowin), 64'd1);
  endtask

  task automatic drain();
    ms_valid = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 300 &&
         (rfq.size() != 0 || trq.size() != 0 || trace_valid); i++)
      step();
    chk("drain_left", 64'(rfq.size() + trq.size()), 64'd0);
    repeat (2) step();
    chk("retire_cnt", retire_cnt, exp_ret());
  endtask

  // Monitor: compares every register write and every trace pop in order.
  initial begin : mon
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rf_we_in_reset", 64'(rf_we), 64'd0);
      end else begin
        chk("trace_wen", 64'(trace_wen), trace_valid ? 64'hF : 64'h0);
        if (rf_we) begin
          if (rfq.size() == 0) begin
            chk("rf_we_unexpected", 64'(rf_we), 64'd0);
          end else begin
            e = rfq.pop_front();
            chk("rf_waddr", 64'(rf_waddr), 64'(e.d));
            chk("rf_wdata", 64'(rf_wdata), 64'(e.r));
          end
        end
        if (trace_valid && trace_ready) begin
          if (trq.size() == 0) begin
            chk("trace_unexpected", 64'(trace_valid), 64'd0);
          end else begin
            e = trq.pop_front();
            chk("trace_pc", 64'(trace_pc), 64'(e.p));
            chk("trace_wnum", 64'(trace_wnum), 64'(e.d));
            chk("trace_wdata", 64'(trace_wdata), 64'(e.r));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] r5;
    ms_valid = 1'b0;
    ms_bus = '0;
    trace_ready = 1'b0;
    reset = 1'b1;
    repeat (2) step();

    chk("rst_allowin", 64'(ws_allowin), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_ds_bus", 64'(ds_bus), 64'd0);
    chk("rst_tvalid", 64'(trace_valid), 64'd0);
    chk("rst_tpc", 64'(trace_pc), 64'd0);
    chk("rst_twen", 64'(trace_wen), 64'd0);
    chk("rst_twnum", 64'(trace_wnum), 64'd0);
    chk("rst_twdata", 64'(trace_wdata), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);

    reset = 1'b0;
    trace_ready = 1'b1;
    step();

    // Single write: rf write one cycle after acceptance, trace the next.
    issue(1'b1, 5'd3, 32'h12345678, 32'h1c000000);
    ms_valid = 1'b0;
    @(negedge clk);
    chk("t1_rf_we", 64'(rf_we), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd3);
    chk("t1_wdata", 64'(rf_wdata), 64'h12345678);
    @(negedge clk);
    chk("t1_tvalid", 64'(trace_valid), 64'd1);
    chk("t1_tpc", 64'(trace_pc), 64'h1c000000);
    chk("t1_twnum", 64'(trace_wnum), 64'd3);
    chk("t1_twdata", 64'(trace_wdata), 64'h12345678);
    chk("t1_twen", 64'(trace_wen), 64'hF);
    step();
    drain();

    // Write to r0 is dropped but still retires.
    issue(1'b1, 5'd0, 32'hdeadbeef, 32'h1c000010);
    ms_valid = 1'b0;
    @(negedge clk);
    chk("r0_rf_we", 64'(rf_we), 64'd0);
    chk("r0_fwd", 64'(ds_bus[AW+DW:DW]), 64'd0);
    chk("r0_tvalid", 64'(trace_valid), 64'd0);
    step();
    drain();

    // Non-writing instruction: no forward, forward data still visible.
    issue(1'b0, 5'd7, 32'h0badf00d, 32'h1c000014);
    ms_valid = 1'b0;
    @(negedge clk);
    chk("nw_fwd_hdr", 64'(ds_bus[AW+DW:DW]), 64'd0);
    chk("nw_fwd_data", 64'(ds_bus[DW-1:0]), 64'h0badf00d);
    chk("nw_rf_we", 64'(rf_we), 64'd0);
    step();
    drain();

    // Back-pressure: four records fill the FIFO, the fifth stalls.
    trace_ready = 1'b0;
    r5 = '0;
    for (int i = 0; i < 5; i++) begin
      r5 = $urandom;
      issue(1'b1, AW'(i + 1), r5, 32'h1000 + 32'(4 * i));
    end
    ms_valid = 1'b0;
    @(negedge clk);
    chk("bp_allowin", 64'(ws_allowin), 64'd0);
    chk("bp_rf_we", 64'(rf_we), 64'd0);
    chk("bp_fwd_valid", 64'(ds_bus[AW+DW]), 64'd1);
    chk("bp_fwd_dest", 64'(ds_bus[AW+DW-1:DW]), 64'd5);
    chk("bp_fwd_data", 64'(ds_bus[DW-1:0]), 64'(r5));
    chk("bp_tvalid", 64'(trace_valid), 64'd1);
    step();
    trace_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_allowin", 64'(ws_allowin), 64'd1);
    chk("bp_release_rf_we", 64'(rf_we), 64'd1);
    step();

    // Push+pop at full left occupancy at 4: a new write stalls again.
    trace_ready = 1'b0;
    issue(1'b1, 5'd9, 32'h99990000, 32'h2000);
    ms_valid = 1'b0;
    @(negedge clk);
    chk("full_kept_allowin", 64'(ws_allowin), 64'd0);
    step();
    drain();

    // Pointer wrap with trace_ready toggling every cycle.
    done = 0;
    trace_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          issue(1'b1, AW'($urandom_range(1, 31)), $urandom,
                32'h3000 + 32'(4 * i));
        ms_valid = 1'b0;
        done = 1;
      end
      begin
        for (int i = 0; i < 2000 && !done; i++) begin
          trace_ready = ~trace_ready;
          step();
        end
      end
    join
    drain();

    // Reset mid-operation: 3 records queued, a 4th in the stage.
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(1'b1, AW'(i + 10), $urandom, 32'h4000 + 32'(4 * i));
    ms_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_tvalid", 64'(trace_valid), 64'd0);
    chk("mr_allowin", 64'(ws_allowin), 64'd1);
    chk("mr_rf_we", 64'(rf_we), 64'd0);
    rfq.delete();
    trq.delete();
    ret_exp = 0;
    step();
    step();
    reset = 1'b0;
    drain();

    // Randomized traffic with random consumer back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          ms_valid = 1'b0;
          repeat ($urandom_range(0, 2)) step();
          issue($urandom_range(0, 3) != 0,
                ($urandom_range(0, 7) == 0) ? AW'(0)
                                            : AW'($urandom_range(1, 31)),
                $urandom, $urandom);
        end
        ms_valid = 1'b0;
        done = 1;
      end
      begin
        for (int i = 0; i < 20000 && !done; i++) begin
          trace_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_trace_stage.md
Name: wb_trace_stage

Overview:
- Parametrised write-back stage. Takes the memory-stage pipeline register, performs the register-file write, and drives the decode-stage hazard/forward bus.
- Commit trace records go into a TRACE_DEPTH FIFO with a valid/ready drain port, so a slow trace consumer back-pressures the pipeline instead of losing records.
- Sits between the memory stage and the register file / trace comparator.

Parameters:
- DATA_W, 32, register and result width; multiple of 8.
- ADDR_W, 5, register index width.
- TRACE_DEPTH, 4, trace FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- ws_allowin  out  1  stage can accept a new instruction this cycle
- ms_to_ws_valid  in  1  memory stage offers an instruction
- ms_to_ws_bus  in  1+ADDR_W+2*DATA_W  packed {gr_we, dest, result, pc}, MSB first
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- ws_to_ds_bus  out  1+ADDR_W+DATA_W  {fwd_valid, fwd_dest, fwd_data}
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer pops head
- trace_pc  out  DATA_W  head pc
- trace_wen  out  DATA_W/8  head byte enables, all ones
- trace_wnum  out  ADDR_W  head register index
- trace_wdata  out  DATA_W  head data
- retire_cnt  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. It clears ws_valid, the FIFO pointers and count, and retire_cnt. The payload register is not reset.
- After reset, every output is 0 except ws_allowin, which is 1.
- Pipeline register:
  - ws_allowin = !ws_valid || ws_ready_go.
  - On ws_allowin, ws_valid <= ms_to_ws_valid.
  - The payload loads when ms_to_ws_valid && ws_allowin.
- Write detection: commit_we = ws_valid && gr_we && dest != 0. A write to register 0 is dropped and produces no trace record.
- Ready-go: ws_ready_go = !commit_we || !fifo_full || (trace_valid && trace_ready).
  - A full FIFO may accept a push in the same cycle as a pop.
  - The combinational path trace_ready -> ws_allowin is intended.
- Retire: retire = ws_valid && ws_ready_go.
  - rf_we = commit_we && ws_ready_go, rf_waddr = dest, rf_wdata = result.
  - Latency: the instruction is accepted in cycle N and written in cycle N+1, or later if stalled.
  - While stalled, rf_we = 0 and the payload holds.
- Forwarding: fwd_valid = commit_we, asserted even while stalled so decode sees the pending write. fwd_dest = commit_we ? dest : 0. fwd_data = result.
- Trace FIFO:
  - On retire with commit_we, push {pc, dest, result} at the tail.
  - Pop when trace_valid && trace_ready.
  - Pointers are log2(TRACE_DEPTH) bits and wrap modulo depth.
  - The count register ranges 0..TRACE_DEPTH. fifo_full = (count == TRACE_DEPTH). trace_valid = (count != 0).
  - Head fields are shown directly (first-word-fall-through). A record pushed in cycle N is visible in cycle N+1.
  - Push and pop in the same cycle leave count unchanged, including at full and at count 1.
  - A pop when empty is ignored.
- trace_wen is all ones whenever trace_valid, otherwise 0.
- Reset asserted mid-operation discards the in-flight instruction and all FIFO records. No rf_we pulse occurs while reset is high.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 every cycle in which retire is high, including non-writing instructions. It wraps at 2^64 and resets to 0.
- Undefined: the counter logic is omitted and retire_cnt is tied to 0.

Test Plan:
- Single instruction, gr_we=1, dest=3, result=0x12345678, pc=0x1c000000, trace_ready=1:
  - Cycle after acceptance: rf_we=1, waddr=3, wdata=0x12345678.
  - Next cycle: trace_valid=1 with the same fields and trace_wen=0xF.
- dest=0 with gr_we=1: rf_we=0, no trace record, retire_cnt increments by 1 (feature on).
- trace_ready=0 with 5 back-to-back writes, TRACE_DEPTH=4:
  - 4 records are pushed.
  - The 5th holds in the stage: ws_allowin=0, rf_we=0, fwd_valid=1.
  - Raising trace_ready lets it retire in the same cycle the head pops.
- Wrap-around: stream 10 writes while trace_ready toggles every cycle. The trace emerges in order with pc values intact across pointer wrap.
- Assert reset with the FIFO holding 3 records and ws_valid=1: trace_valid=0 and ws_allowin=1 immediately, and no rf_we during reset.
- Same-cycle push and pop at count=4: count stays 4, and the new record appears after the 3 older ones.
